// File: rtl/dmem_arbiter_ctrl_if.sv
// rtl/dmem_arbiter_ctrl_if.sv - requester A/B handshake and DataMemory port bundle
interface dmem_arbiter_ctrl_if;
  logic        a_req_valid;
  logic        a_req_ready;
  logic [31:0] a_addr;
  logic        a_we;
  logic [1:0]  a_size;
  logic        a_unsigned;
  logic [31:0] a_wdata;
  logic        a_rsp_valid;
  logic        a_rsp_err;
  logic [31:0] a_rdata;

  logic        b_req_valid;
  logic        b_req_ready;
  logic [31:0] b_addr;
  logic        b_we;
  logic [1:0]  b_size;
  logic        b_unsigned;
  logic [31:0] b_wdata;
  logic        b_rsp_valid;
  logic        b_rsp_err;
  logic [31:0] b_rdata;

  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_write_enable;
  logic [31:0] mem_read_data;

  modport slave (
    input  a_req_valid, a_addr, a_we, a_size, a_unsigned, a_wdata,
    output a_req_ready, a_rsp_valid, a_rsp_err, a_rdata,
    input  b_req_valid, b_addr, b_we, b_size, b_unsigned, b_wdata,
    output b_req_ready, b_rsp_valid, b_rsp_err, b_rdata,
    output mem_addr, mem_write_data, mem_write_enable,
    input  mem_read_data
  );

  modport master (
    output a_req_valid, a_addr, a_we, a_size, a_unsigned, a_wdata,
    input  a_req_ready, a_rsp_valid, a_rsp_err, a_rdata,
    output b_req_valid, b_addr, b_we, b_size, b_unsigned, b_wdata,
    input  b_req_ready, b_rsp_valid, b_rsp_err, b_rdata,
    input  mem_addr, mem_write_data, mem_write_enable,
    output mem_read_data
  );
endinterface

// File: rtl/dmem_arbiter_ctrl.sv
// rtl/dmem_arbiter_ctrl.sv - two-requester DataMemory arbiter with sub-word read-modify-write
module dmem_arbiter_ctrl #(
  parameter bit RR_ENABLE       = 1'b1,
  parameter bit ERR_ON_MISALIGN = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  dmem_arbiter_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, MERGE, RESP} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  state_t      r_state;
  logic        r_last_b;
  logic        r_id_b;
  logic [31:0] r_addr;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [31:0] r_wdata;
  logic [31:0] r_rmw_buf;
  logic        r_rsp_valid;
  logic        r_rsp_err;
  logic [31:0] r_rdata;

  logic        w_grant_b;
  logic        w_accept;
  logic        w_err;
  logic        w_sub_store;
  logic        w_word_store;
  logic [4:0]  w_shift;
  logic [31:0] w_rd_shifted;
  logic [31:0] w_load_val;
  logic [31:0] w_mask;
  logic [31:0] w_merged;
  logic [31:0] w_mem_wdata;

  // B wins only when A is idle, or under round-robin when A took the previous grant
  assign w_grant_b = bus.b_req_valid && (!bus.a_req_valid || (RR_ENABLE && !r_last_b));
  assign w_accept  = (r_state == IDLE) && (bus.a_req_valid || bus.b_req_valid);

  assign bus.a_req_ready = (r_state == IDLE) && bus.a_req_valid && !w_grant_b;
  assign bus.b_req_ready = (r_state == IDLE) && w_grant_b;

  assign w_err = (r_size == SZ_RSVD) ||
                 (ERR_ON_MISALIGN && (((r_size == SZ_HALF) && r_addr[0]) ||
                                      ((r_size == SZ_WORD) && (r_addr[1:0] != 2'b00))));
  assign w_sub_store  = r_we && ((r_size == SZ_BYTE) || (r_size == SZ_HALF));
  assign w_word_store = (r_state == EXEC) && r_we && (r_size == SZ_WORD) && !w_err;

  // With forced alignment the ignored low bits simply never reach the lane shift
  always_comb begin
    w_shift = 5'd0;
    w_mask  = 32'hFFFF_FFFF;
    case (r_size)
      SZ_BYTE: begin
        w_shift = {r_addr[1:0], 3'b000};
        w_mask  = 32'h0000_00FF << w_shift;
      end
      SZ_HALF: begin
        w_shift = {r_addr[1], 4'b0000};
        w_mask  = 32'h0000_FFFF << w_shift;
      end
      default: ;
    endcase
  end

  assign w_rd_shifted = bus.mem_read_data >> w_shift;
  assign w_merged     = (r_rmw_buf & ~w_mask) | ((r_wdata << w_shift) & w_mask);

  always_comb begin
    w_load_val = bus.mem_read_data;
    case (r_size)
      SZ_BYTE: w_load_val = {{24{!r_unsigned && w_rd_shifted[7]}}, w_rd_shifted[7:0]};
      SZ_HALF: w_load_val = {{16{!r_unsigned && w_rd_shifted[15]}}, w_rd_shifted[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    w_mem_wdata = 32'h0;
    if (r_state == MERGE)
      w_mem_wdata = w_merged;
    else if (w_word_store)
      w_mem_wdata = r_wdata;
  end

  // Write strobe decodes from state so an asynchronous reset kills it at once
  assign bus.mem_write_enable = w_word_store || (r_state == MERGE);
  assign bus.mem_write_data   = w_mem_wdata;
  assign bus.mem_addr         = {2'b00, r_addr[31:2]};

  assign bus.a_rsp_valid = r_rsp_valid && !r_id_b;
  assign bus.a_rsp_err   = r_rsp_err && !r_id_b;
  assign bus.a_rdata     = r_id_b ? 32'h0 : r_rdata;
  assign bus.b_rsp_valid = r_rsp_valid && r_id_b;
  assign bus.b_rsp_err   = r_rsp_err && r_id_b;
  assign bus.b_rdata     = r_id_b ? r_rdata : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_last_b    <= 1'b1;
      r_id_b      <= 1'b0;
      r_addr      <= 32'h0;
      r_we        <= 1'b0;
      r_size      <= SZ_BYTE;
      r_unsigned  <= 1'b0;
      r_wdata     <= 32'h0;
      r_rmw_buf   <= 32'h0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rdata     <= 32'h0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_id_b     <= w_grant_b;
            r_last_b   <= w_grant_b;
            r_addr     <= w_grant_b ? bus.b_addr     : bus.a_addr;
            r_we       <= w_grant_b ? bus.b_we       : bus.a_we;
            r_size     <= w_grant_b ? bus.b_size     : bus.a_size;
            r_unsigned <= w_grant_b ? bus.b_unsigned : bus.a_unsigned;
            r_wdata    <= w_grant_b ? bus.b_wdata    : bus.a_wdata;
            r_state    <= EXEC;
          end
        end
        EXEC: begin
          if (w_err) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rdata     <= 32'h0;
            r_state     <= RESP;
          end else if (!r_we) begin
            r_rsp_valid <= 1'b1;
            r_rdata     <= w_load_val;
            r_state     <= RESP;
          end else if (w_sub_store) begin
            r_rmw_buf <= bus.mem_read_data;
            r_state   <= MERGE;
          end else begin
            r_rsp_valid <= 1'b1;
            r_rdata     <= 32'h0;
            r_state     <= RESP;
          end
        end
        MERGE: begin
          r_rsp_valid <= 1'b1;
          r_rdata     <= 32'h0;
          r_state     <= RESP;
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_rsp_err   <= 1'b0;
          r_rdata     <= 32'h0;
          r_state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_arbiter_ctrl.sv
// tb/tb_dmem_arbiter_ctrl.sv - scoreboard bench for dmem_arbiter_ctrl
`timescale 1ns/1ps
module tb_dmem_arbiter_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_ctrl_if bus();
  dmem_arbiter_ctrl_if bus_fp();

  dmem_arbiter_ctrl #(.RR_ENABLE(1'b1), .ERR_ON_MISALIGN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  dmem_arbiter_ctrl #(.RR_ENABLE(1'b0), .ERR_ON_MISALIGN(1'b1)) u_dut_fp (
    .clk(clk), .rst_n(rst_n), .bus(bus_fp));

  logic [31:0] mem [0:63];
  logic [31:0] ref_mem [0:63];
  assign bus.mem_read_data    = mem[bus.mem_addr[5:0]];
  assign bus_fp.mem_read_data = 32'h0;
  always @(posedge clk) if (bus.mem_write_enable) mem[bus.mem_addr[5:0]] <= bus.mem_write_data;

  typedef struct packed { logic b; logic err; logic [31:0] rdata; int unsigned cyc; } rsp_t;
  typedef struct packed { logic [31:0] waddr; logic [31:0] wdata; int unsigned cyc; } wr_t;

  rsp_t rsp_q[$];
  wr_t  wr_q[$];
  logic grant_log[$];
  logic fp_log[$];
  int unsigned cyc = 0;
  int n_total = 0;
  int n_bad = 0;
  logic [31:0] last_rdata [2];
  logic        last_err [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model(input logic b, input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] w, nw, rd;
    logic [7:0]  by;
    logic [15:0] hw;
    logic        err;
    rsp_t r;
    wr_t  wr;
    w   = ref_mem[addr[7:2]];
    err = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
    case (addr[1:0])
      2'd0: by = w[7:0];
      2'd1: by = w[15:8];
      2'd2: by = w[23:16];
      default: by = w[31:24];
    endcase
    hw = addr[1] ? w[31:16] : w[15:0];
    rd = 32'h0;
    nw = w;
    if (!err && !we) begin
      case (size)
        2'b00:   rd = uns ? {24'h0, by} : {{24{by[7]}}, by};
        2'b01:   rd = uns ? {16'h0, hw} : {{16{hw[15]}}, hw};
        default: rd = w;
      endcase
    end
    if (!err && we) begin
      case (size)
        2'b00: case (addr[1:0])
          2'd0: nw[7:0]   = wdata[7:0];
          2'd1: nw[15:8]  = wdata[7:0];
          2'd2: nw[23:16] = wdata[7:0];
          default: nw[31:24] = wdata[7:0];
        endcase
        2'b01: if (addr[1]) nw[31:16] = wdata[15:0]; else nw[15:0] = wdata[15:0];
        default: nw = wdata;
      endcase
      ref_mem[addr[7:2]] = nw;
      wr.waddr = {2'b00, addr[31:2]};
      wr.wdata = nw;
      wr.cyc   = cyc + ((size == 2'b10) ? 1 : 2);
      wr_q.push_back(wr);
    end
    r.b     = b;
    r.err   = err;
    r.rdata = rd;
    r.cyc   = cyc + ((!err && we && size != 2'b10) ? 3 : 2);
    rsp_q.push_back(r);
  endtask

  task automatic check_rsp(input logic b, input logic err, input logic [31:0] rd);
    rsp_t e;
    last_rdata[b] = rd;
    last_err[b]   = err;
    if (rsp_q.size() == 0) begin
      chk("rsp_spurious", 32'(rsp_q.size()), 32'd1);
    end else begin
      e = rsp_q.pop_front();
      chk("rsp_owner", {31'b0, b}, {31'b0, e.b});
      chk("rsp_err", {31'b0, err}, {31'b0, e.err});
      chk("rsp_rdata", rd, e.rdata);
      chk("rsp_cycle", cyc, e.cyc);
    end
  endtask

  task automatic check_wr();
    wr_t e;
    if (wr_q.size() == 0) begin
      chk("wr_spurious", 32'(wr_q.size()), 32'd1);
    end else begin
      e = wr_q.pop_front();
      chk("wr_addr", bus.mem_addr, e.waddr);
      chk("wr_data", bus.mem_write_data, e.wdata);
      chk("wr_cycle", cyc, e.cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.a_req_valid && bus.a_req_ready) begin
        grant_log.push_back(1'b0);
        model(1'b0, bus.a_we, bus.a_size, bus.a_unsigned, bus.a_addr, bus.a_wdata);
      end
      if (bus.b_req_valid && bus.b_req_ready) begin
        grant_log.push_back(1'b1);
        model(1'b1, bus.b_we, bus.b_size, bus.b_unsigned, bus.b_addr, bus.b_wdata);
      end
      if (bus.a_rsp_valid) check_rsp(1'b0, bus.a_rsp_err, bus.a_rdata);
      if (bus.b_rsp_valid) check_rsp(1'b1, bus.b_rsp_err, bus.b_rdata);
      if (bus.mem_write_enable) check_wr();
      if (bus_fp.a_req_valid && bus_fp.a_req_ready) fp_log.push_back(1'b0);
      if (bus_fp.b_req_valid && bus_fp.b_req_ready) fp_log.push_back(1'b1);
    end
  end

  task automatic drive(input logic b, input logic v, input logic we, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
    if (!b) begin
      bus.a_req_valid = v; bus.a_we = we; bus.a_size = size;
      bus.a_unsigned = uns; bus.a_addr = addr; bus.a_wdata = wdata;
    end else begin
      bus.b_req_valid = v; bus.b_we = we; bus.b_size = size;
      bus.b_unsigned = uns; bus.b_addr = addr; bus.b_wdata = wdata;
    end
  endtask

  task automatic wait_accept(input logic b);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = b ? bus.b_req_ready : bus.a_req_ready;
    end
    chk("accept", {31'b0, ok}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk); #1;
      ok = (rsp_q.size() == 0) && (wr_q.size() == 0);
    end
    chk("drain", {31'b0, ok}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic b, input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    drive(b, 1'b1, we, size, uns, addr, wdata);
    wait_accept(b);
    drive(b, 1'b0, we, size, uns, addr, wdata);
    drain();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] <= 32'h0;
      ref_mem[i] = 32'h0;
    end
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    bus_fp.a_req_valid = 1'b0; bus_fp.a_we = 1'b0; bus_fp.a_size = 2'b10;
    bus_fp.a_unsigned = 1'b0; bus_fp.a_addr = 32'h0; bus_fp.a_wdata = 32'h0;
    bus_fp.b_req_valid = 1'b0; bus_fp.b_we = 1'b0; bus_fp.b_size = 2'b10;
    bus_fp.b_unsigned = 1'b0; bus_fp.b_addr = 32'h0; bus_fp.b_wdata = 32'h0;

    repeat (3) @(posedge clk); #1;
    chk("rst_a_ready", {31'b0, bus.a_req_ready}, 32'd0);
    chk("rst_b_ready", {31'b0, bus.b_req_ready}, 32'd0);
    chk("rst_a_rsp", {30'b0, bus.a_rsp_valid, bus.a_rsp_err}, 32'd0);
    chk("rst_b_rsp", {30'b0, bus.b_rsp_valid, bus.b_rsp_err}, 32'd0);
    chk("rst_we", {31'b0, bus.mem_write_enable}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_write_data, 32'd0);
    chk("rst_rdata", bus.a_rdata | bus.b_rdata, 32'd0);
    rst_n = 1'b1;

    // both requesters held valid on both instances: round-robin alternates, fixed priority keeps A
    grant_log.delete();
    fp_log.delete();
    drive(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'hC, 32'h0);
    bus_fp.a_req_valid = 1'b1;
    bus_fp.b_req_valid = 1'b1;
    repeat (12) @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'hC, 32'h0);
    bus_fp.a_req_valid = 1'b0;
    bus_fp.b_req_valid = 1'b0;
    drain();
    chk("rr_grants", 32'(grant_log.size()), 32'd4);
    for (int i = 0; i < grant_log.size() && i < 4; i++)
      chk($sformatf("rr_grant%0d", i), {31'b0, grant_log[i]}, 32'(i % 2));
    chk("fp_grants", 32'(fp_log.size()), 32'd4);
    for (int i = 0; i < fp_log.size() && i < 4; i++)
      chk($sformatf("fp_grant%0d", i), {31'b0, fp_log[i]}, 32'd0);

    issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h8, 32'hDEADBEEF);
    issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
    chk("ld_word", last_rdata[0], 32'hDEADBEEF);
    chk("ld_word_err", {31'b0, last_err[0]}, 32'd0);

    issue(1'b0, 1'b1, 2'b00, 1'b0, 32'h9, 32'hCAFE0011);
    chk("byte_merge_mem", mem[2], 32'hDEAD11EF);
    issue(1'b0, 1'b0, 2'b00, 1'b0, 32'h8, 32'h0);
    chk("ld_byte_signed", last_rdata[0], 32'hFFFFFFEF);
    issue(1'b0, 1'b0, 2'b01, 1'b1, 32'hA, 32'h0);
    chk("ld_half_unsigned", last_rdata[0], 32'h0000DEAD);
    issue(1'b1, 1'b1, 2'b01, 1'b0, 32'h6, 32'h0000ABCD);
    issue(1'b1, 1'b0, 2'b01, 1'b0, 32'h6, 32'h0);
    chk("ld_half_signed", last_rdata[1], 32'hFFFFABCD);

    issue(1'b0, 1'b0, 2'b01, 1'b0, 32'h3, 32'h0);
    chk("err_half_flag", {31'b0, last_err[0]}, 32'd1);
    chk("err_half_rdata", last_rdata[0], 32'h0);
    issue(1'b0, 1'b1, 2'b11, 1'b0, 32'h10, 32'hFFFFFFFF);
    chk("err_rsvd_flag", {31'b0, last_err[0]}, 32'd1);
    chk("err_rsvd_nowrite", mem[4], 32'h0);
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h22, 32'h0);
    chk("err_word_flag", {31'b0, last_err[1]}, 32'd1);

    // B accepted, then its own inputs and A's inputs churn while the controller is busy
    drive(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'h5A5AA5A5);
    wait_accept(1'b1);
    drive(1'b1, 1'b0, 1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 1'($urandom), 2'($urandom), 1'($urandom),
            32'h20 + $urandom_range(0, 31), $urandom);
      @(negedge clk);
      chk("a_ready_busy", {31'b0, bus.a_req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    wait_accept(1'b0);
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    drain();
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("b_registered_store", last_rdata[1], 32'h5A5AA5A5);

    // reset during MERGE of a byte store must abort without writing
    issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h4, 32'h12345678);
    drive(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 32'h5, 32'h77);
    wait_accept(1'b0);
    drive(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h5, 32'h77);
    @(posedge clk); #1;
    chk("merge_we", {31'b0, bus.mem_write_enable}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_we_async", {31'b0, bus.mem_write_enable}, 32'd0);
    chk("rst_no_rsp", {31'b0, bus.a_rsp_valid}, 32'd0);
    rsp_q.delete();
    wr_q.delete();
    ref_mem[1] = 32'h12345678;
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_mem_unchanged", mem[1], 32'h12345678);
    drive(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
    #1;
    chk("idle_after_rst", {31'b0, bus.a_req_ready}, 32'd1);
    issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
    chk("rst_reload", last_rdata[0], 32'h12345678);

    repeat (4) @(posedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter_ctrl.md
Name: dmem_arbiter_ctrl

Overview:
Sequencing controller and two-port arbiter for the word-wide DataMemory (32-bit addr, 32-bit write_data/read_data, write_enable; posedge write; combinational read).
Requester A (core MEM stage) and requester B (debug/DMA loader) issue byte-addressed loads and stores of byte, half or word size.
The block arbitrates between A and B, performs sub-word stores as registered read-modify-write, and returns sign- or zero-extended load data.
It sits between the pipeline/debug logic and the single DataMemory instance.

Parameters:
RR_ENABLE, 1, 1 = round-robin between A and B; 0 = fixed priority, A always wins.
ERR_ON_MISALIGN, 1, 1 = misaligned access returns rsp_err without memory access; 0 = low address bits are ignored (forced alignment).

Ports:
clk  in  1  system clock, all state updates on posedge
rst_n  in  1  asynchronous active-low reset
a_req_valid  in  1  A request valid
a_req_ready  out  1  A request accepted this cycle
a_addr  in  32  A byte address
a_we  in  1  1 = store, 0 = load
a_size  in  2  00 byte, 01 half, 10 word, 11 reserved
a_unsigned  in  1  load zero-extend (1) or sign-extend (0)
a_wdata  in  32  store data, right-aligned
a_rsp_valid  out  1  one-cycle response pulse
a_rsp_err  out  1  misaligned or reserved-size error, valid with a_rsp_valid
a_rdata  out  32  load result; 0 for stores and errors
b_* (b_req_valid … b_rdata)  same directions, widths and meanings as the a_* ports, for requester B
mem_addr  out  32  to DataMemory addr, word index = {2'b00, addr[31:2]}
mem_write_data  out  32  to DataMemory write_data
mem_write_enable  out  1  to DataMemory write_enable
mem_read_data  in  32  from DataMemory read_data

Behaviour:
- FSM states: IDLE, EXEC, MERGE, RESP. Reset state is IDLE.
- Reset values: all *_req_ready, *_rsp_valid, *_rsp_err and mem_write_enable are 0; *_rdata, mem_addr and mem_write_data are 0; last_grant = B, so A wins the first tie.
- IDLE: grant one valid requester.
  - If both are valid and RR_ENABLE=1, grant the one that is not last_grant; if RR_ENABLE=0, grant A.
  - x_req_ready is asserted combinationally only in IDLE, only to the granted requester.
  - On accept, register addr, we, size, unsigned, wdata and grant id; update last_grant; go to EXEC.
- EXEC: drive mem_addr from the registered addr.
  - Error cases: reserved size; half with addr[0]=1; word with addr[1:0]≠0 (when ERR_ON_MISALIGN=1). On error, no write; set err flag; go to RESP.
  - Load: capture the lane-selected, extended mem_read_data into the result register; go to RESP.
  - Word store: mem_write_enable=1, mem_write_data=wdata; go to RESP.
  - Byte or half store: capture mem_read_data into rmw_buf, no write; go to MERGE.
- MERGE: mem_write_enable=1. mem_write_data = rmw_buf with lane addr[1:0] (byte) or lanes addr[1]*2+:2 (half) replaced by wdata[7:0] or wdata[15:0]. Go to RESP.
- RESP: assert rsp_valid for exactly 1 cycle to the granted requester only, with rdata and rsp_err; return to IDLE. No new accept occurs in RESP.
- Latency from accept cycle T:
  - Loads, word stores and errors: rsp_valid at T+2.
  - Sub-word stores: rsp_valid at T+3.
  - Maximum throughput: one request per 3 cycles, or per 4 cycles for sub-word stores.
- mem_write_enable is high only in EXEC (word store) or MERGE, for exactly 1 cycle per store. It is never asserted for loads or errors.
- Load extension: byte sign-extends from bit 7, half from bit 15, unless *_unsigned=1. A word load returns the word unchanged.
- Requester inputs may change after the accept cycle; the controller uses only registered copies.
- A request still valid but not granted stays pending with ready=0. It is never dropped and never starved: with RR_ENABLE=1 it is granted within 1 arbitration.
- Reset asserted mid-operation forces IDLE immediately and clears mem_write_enable asynchronously. The in-flight request is discarded with no response; a partial RMW never writes.

Test Plan:
- A stores word 0xDEADBEEF @0x8, then loads word @0x8 → mem_write_enable pulses once with mem_addr=2; load a_rsp_valid at T+2 with a_rdata=0xDEADBEEF, a_rsp_err=0.
- With word @0x8 = 0xDEADBEEF, A stores byte 0x11 @0x9 → write at T+2 of 0xDEAD11EF; a_rsp_valid at T+3. Then a signed byte load @0x8 → 0xFFFFFFEF; unsigned half load @0xA → 0x0000DEAD.
- A and B both valid continuously after reset → grants alternate A, B, A, B; each rsp_valid goes only to its owner. With RR_ENABLE=0 → A always wins while valid.
- A loads half @0x3, and separately issues size=11 → a_rsp_err=1, a_rdata=0, no mem_write_enable pulse, response at T+2.
- rst_n dropped during MERGE of a byte store @0x4 → mem_write_enable=0 immediately, memory word @0x4 unchanged, no rsp_valid, FSM in IDLE after release.
- B holds valid with changing a_* inputs after its accept → the response reflects the registered request; a_req_ready=0 throughout the busy period.
